hwag_vr_capture: RTL and testbench

Input conditioning stage directly upstream of the angle generator core. It synchronises and debounces the raw crank VR comparator signal and detects its active edges. It measures the tooth period in clk cycles and flags the missing-tooth gap. The core consumes the filtered signal, the per-tooth strobe, the period and the gap flag.

---
 rtl/hwag_vr_pkg.sv | 21 ++
 rtl/hwag_vr_filter.sv | 60 ++++++
 rtl/hwag_vr_capture.sv | 107 ++++++++++
 tb/tb_hwag_vr_capture.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwag_vr_pkg.sv
// Shared types and constants for the crank VR input conditioning stage.
package hwag_vr_pkg;

  // Default widths of the tooth period counter and the debounce counter.
  localparam int CNT_WIDTH_DEF  = 24;
  localparam int FILT_WIDTH_DEF = 8;

  // Gap ratio: a tooth is the gap when GAP_DEN*period > GAP_NUM*prev_period,
  // i.e. the tooth is more than 1.5x as long as the one before it.
  localparam int GAP_NUM = 3;
  localparam int GAP_DEN = 2;

  // Capture state machine: IDLE until the first edge, ARM while the first
  // (unreferenced) period is measured, RUN while producing tooth strobes.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } vr_state_t;

endpackage

// File: rtl/hwag_vr_filter.sv
// VR input front end: two-flop synchroniser, debounce filter and active-edge
// detection on the filtered level.
module hwag_vr_filter
  import hwag_vr_pkg::*;
#(
  parameter int FILT_WIDTH = FILT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vr_in,
  input  logic [FILT_WIDTH-1:0] filt_top,
  input  logic                  edge_fall,
  output logic                  vr_out,
  output logic                  act_edge
);

  localparam logic [FILT_WIDTH-1:0] FILT_ONE = FILT_WIDTH'(1);

  logic [1:0]            sync_q;
  logic                  vr_sync;
  logic [FILT_WIDTH-1:0] filt_cnt;
  logic                  vr_prev;

  assign vr_sync = sync_q[1];

  // Two-flop synchroniser for the asynchronous comparator output.
  // NOTE: every sequential block uses non-blocking assignments so all flops
  // sample their inputs from the same clock edge regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b00;
    else      sync_q <= {sync_q[0], vr_in};
  end

  // Debounce: the synchronised level must disagree with vr_out for
  // filt_top+1 consecutive cycles before vr_out follows it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vr_out   <= 1'b0;
      filt_cnt <= '0;
    end else if (vr_sync == vr_out) begin
      filt_cnt <= '0;
    end else if (filt_cnt >= filt_top) begin
      vr_out   <= vr_sync;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FILT_ONE;
    end
  end

  // Previous filtered level, used to find transitions of vr_out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vr_prev <= 1'b0;
    else      vr_prev <= vr_out;
  end

  // NOTE: the edge pulse is decoded from two registers with a continuous
  // assign, so it is glitch-free in practice and lasts exactly one cycle.
  assign act_edge = edge_fall ? (vr_prev & ~vr_out) : (~vr_prev & vr_out);

endmodule

// File: rtl/hwag_vr_capture.sv
// Crank VR capture: filters the raw VR signal, measures the tooth period in
// clk cycles and flags the missing-tooth gap for the angle generator core.
// Optional feature macro: HWAG_VR_GAP_EN (gap comparator and prev_period).
// Without it gap_stb is constant 0.
module hwag_vr_capture
  import hwag_vr_pkg::*;
#(
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int FILT_WIDTH = FILT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vr_in,
  input  logic [FILT_WIDTH-1:0] filt_top,
  input  logic                  edge_fall,
  output logic                  vr_out,
  output logic                  tooth_stb,
  output logic [CNT_WIDTH-1:0]  tooth_period,
  output logic                  gap_stb,
  output logic                  period_ovf
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  vr_state_t            state;
  logic [CNT_WIDTH-1:0] per_cnt;
  logic                 act_edge;
  logic                 sat;
  logic                 gap_hit;

  hwag_vr_filter #(
    .FILT_WIDTH (FILT_WIDTH)
  ) u_filter (
    .clk       (clk),
    .rst       (rst),
    .vr_in     (vr_in),
    .filt_top  (filt_top),
    .edge_fall (edge_fall),
    .vr_out    (vr_out),
    .act_edge  (act_edge)
  );

  assign sat = (per_cnt == CNT_MAX);

`ifdef HWAG_VR_GAP_EN
  logic [CNT_WIDTH-1:0] prev_period;
  logic [CNT_WIDTH+1:0] gap_lhs;
  logic [CNT_WIDTH+1:0] gap_rhs;

  // Two extra bits hold 3*all-ones without wrapping.
  assign gap_lhs = {2'b00, per_cnt}     * (CNT_WIDTH+2)'(GAP_DEN);
  assign gap_rhs = {2'b00, prev_period} * (CNT_WIDTH+2)'(GAP_NUM);
  assign gap_hit = (gap_lhs > gap_rhs);

  // Reference period for the gap test; the gap tooth itself becomes the
  // reference for the next tooth, so that tooth never reads as a gap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            prev_period <= '0;
    else if (act_edge && state != IDLE) prev_period <= per_cnt;
  end
`else
  assign gap_hit = 1'b0;
`endif

  // Period counter, state machine and registered strobes/outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      per_cnt      <= '0;
      tooth_period <= '0;
      tooth_stb    <= 1'b0;
      gap_stb      <= 1'b0;
      period_ovf   <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle and are raised only on an
      // edge, which keeps them single-cycle without extra clearing logic.
      tooth_stb <= 1'b0;
      gap_stb   <= 1'b0;
      if (act_edge) begin
        // The edge cycle counts as cycle 1 of the next period; an edge that
        // coincides with saturation wins and latches all-ones.
        per_cnt    <= CNT_ONE;
        period_ovf <= 1'b0;
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            tooth_period <= per_cnt;
            state        <= RUN;
          end
          RUN: begin
            tooth_period <= per_cnt;
            tooth_stb    <= 1'b1;
            gap_stb      <= gap_hit;
          end
          default: state <= IDLE;
        endcase
      end else if (sat) begin
        period_ovf <= 1'b1;
        state      <= IDLE;
      end else begin
        per_cnt <= per_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_hwag_vr_capture.sv
// Directed bench for hwag_vr_capture: a default-width instance and an 8-bit
// period counter instance share the same stimulus.
module tb_hwag_vr_capture;

`ifdef HWAG_VR_GAP_EN
  localparam int GAP_ON = 1;
`else
  localparam int GAP_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        vr_in;
  logic [7:0]  filt_top;
  logic        edge_fall;

  logic        vr_out, tooth_stb, gap_stb, period_ovf;
  logic [23:0] tooth_period;
  logic        vr_out8, tooth_stb8, gap_stb8, period_ovf8;
  logic [7:0]  tooth_period8;

  int n_cmp = 0;
  int n_err = 0;

  // Per-tooth observations collected by run_tooth.
  int          t_stb, t_gap, t_pos, t8_stb, t8_ovf;
  logic [23:0] t_per;
  logic [7:0]  t8_per;

  always #5 clk = ~clk;

  hwag_vr_capture u_dut (
    .clk          (clk),
    .rst          (rst),
    .vr_in        (vr_in),
    .filt_top     (filt_top),
    .edge_fall    (edge_fall),
    .vr_out       (vr_out),
    .tooth_stb    (tooth_stb),
    .tooth_period (tooth_period),
    .gap_stb      (gap_stb),
    .period_ovf   (period_ovf)
  );

  hwag_vr_capture #(.CNT_WIDTH(8), .FILT_WIDTH(8)) u_dut8 (
    .clk          (clk),
    .rst          (rst),
    .vr_in        (vr_in),
    .filt_top     (filt_top),
    .edge_fall    (edge_fall),
    .vr_out       (vr_out8),
    .tooth_stb    (tooth_stb8),
    .tooth_period (tooth_period8),
    .gap_stb      (gap_stb8),
    .period_ovf   (period_ovf8)
  );

  task automatic do_reset();
    rst   = 1'b0;
    vr_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // One tooth of len cycles: rising at i=0, high for len/2 cycles.
  task automatic run_tooth(input int len);
    t_stb = 0; t_gap = 0; t_pos = -1; t_per = '0;
    t8_stb = 0; t8_ovf = 0; t8_per = '0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (tooth_stb) begin
        t_stb++;
        t_per = tooth_period;
        if (t_pos < 0) t_pos = i;
      end
      if (gap_stb) t_gap++;
      if (tooth_stb8) begin
        t8_stb++;
        t8_per = tooth_period8;
      end
      if (period_ovf8) t8_ovf++;
      vr_in = (i < len / 2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; vr_in = 1'b1; filt_top = 8'd0; edge_fall = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({vr_out, tooth_stb, gap_stb, period_ovf, tooth_period} !== 28'd0) begin
      n_err++;
      $display("FAIL reset_dut: got %h want 0", {vr_out, tooth_stb, gap_stb, period_ovf, tooth_period});
    end
    n_cmp++;
    if ({vr_out8, tooth_stb8, gap_stb8, period_ovf8, tooth_period8} !== 12'd0) begin
      n_err++;
      $display("FAIL reset_dut8: got %h want 0", {vr_out8, tooth_stb8, gap_stb8, period_ovf8, tooth_period8});
    end
    vr_in = 1'b0;
  endtask

  task automatic test_filter();
    int seen, rise, fall;
    filt_top = 8'd3;
    do_reset();
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (vr_out) seen++;
      vr_in = (i < 3);
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL filter_glitch: vr_out high %0d cycles, want 0", seen);
    end
    rise = -1; fall = -1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (vr_out && rise < 0) rise = i;
      if (!vr_out && rise >= 0 && fall < 0) fall = i;
      vr_in = (i < 10);
    end
    n_cmp++;
    if (rise !== 6) begin
      n_err++;
      $display("FAIL filter_rise_latency: got %0d want 6", rise);
    end
    n_cmp++;
    if (fall !== 16) begin
      n_err++;
      $display("FAIL filter_fall_latency: got %0d want 16", fall);
    end
    filt_top = 8'd0;
  endtask

  task automatic test_square_wave();
    filt_top = 8'd0; edge_fall = 1'b0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      run_tooth(256);
      n_cmp++;
      if (t_stb !== ((k >= 2) ? 1 : 0)) begin
        n_err++;
        $display("FAIL square_stb[%0d]: got %0d want %0d", k, t_stb, (k >= 2) ? 1 : 0);
      end
      if (k >= 2) begin
        n_cmp++;
        if (t_per !== 24'd256 || t_gap !== 0 || t_pos !== 4) begin
          n_err++;
          $display("FAIL square_tooth[%0d]: per %0d gap %0d pos %0d, want 256 0 4", k, t_per, t_gap, t_pos);
        end
      end
    end
  endtask

  task automatic test_edge_fall();
    edge_fall = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      run_tooth(200);
      n_cmp++;
      if (t_stb !== ((k >= 2) ? 1 : 0)) begin
        n_err++;
        $display("FAIL fall_stb[%0d]: got %0d want %0d", k, t_stb, (k >= 2) ? 1 : 0);
      end
      if (k >= 2) begin
        n_cmp++;
        if (t_per !== 24'd200 || t_pos !== 104) begin
          n_err++;
          $display("FAIL fall_tooth[%0d]: per %0d pos %0d, want 200 104", k, t_per, t_pos);
        end
      end
    end
    edge_fall = 1'b0;
  endtask

  // 60-2 wheel: 58 teeth of 256, one 768 gap, then normal teeth.
  task automatic test_wheel();
    int exp_per, exp_gap;
    do_reset();
    for (int k = 0; k < 61; k++) begin
      run_tooth((k == 58) ? 768 : 256);
      exp_per = (k == 59) ? 768 : 256;
      exp_gap = (k == 59) ? GAP_ON : 0;
      n_cmp++;
      if (t_stb !== ((k >= 2) ? 1 : 0)) begin
        n_err++;
        $display("FAIL wheel_stb[%0d]: got %0d want %0d", k, t_stb, (k >= 2) ? 1 : 0);
      end
      if (k >= 2) begin
        n_cmp++;
        if (t_per !== 24'(exp_per) || t_gap !== exp_gap) begin
          n_err++;
          $display("FAIL wheel_tooth[%0d]: per %0d gap %0d, want %0d %0d", k, t_per, t_gap, exp_per, exp_gap);
        end
      end
    end
  endtask

  task automatic test_gap_boundary();
    int lens    [6] = '{256, 256, 384, 256, 385, 256};
    int exp_per [6] = '{0, 0, 256, 384, 256, 385};
    int exp_gap [6] = '{0, 0, 0, 0, 0, GAP_ON};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      run_tooth(lens[k]);
      if (k >= 2) begin
        n_cmp++;
        if (t_stb !== 1 || t_per !== 24'(exp_per[k]) || t_gap !== exp_gap[k]) begin
          n_err++;
          $display("FAIL gap_boundary[%0d]: stb %0d per %0d gap %0d, want 1 %0d %0d",
                   k, t_stb, t_per, t_gap, exp_per[k], exp_gap[k]);
        end
      end
    end
  endtask

  // 8-bit counter: 300 silent cycles in RUN saturate the period counter.
  task automatic test_overflow();
    int stb_seen;
    do_reset();
    for (int k = 0; k < 3; k++) run_tooth(100);
    n_cmp++;
    if (t8_stb !== 1 || t8_per !== 8'd100) begin
      n_err++;
      $display("FAIL ovf_pre_run: stb %0d per %0d, want 1 100", t8_stb, t8_per);
    end
    stb_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tooth_stb8) stb_seen++;
      vr_in = 1'b0;
    end
    n_cmp++;
    if (period_ovf8 !== 1'b1 || stb_seen !== 0) begin
      n_err++;
      $display("FAIL ovf_set: ovf %0b stb %0d, want 1 0", period_ovf8, stb_seen);
    end
    run_tooth(100);
    n_cmp++;
    if (t8_stb !== 0 || period_ovf8 !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear_edge: stb %0d ovf %0b, want 0 0", t8_stb, period_ovf8);
    end
    run_tooth(100);
    n_cmp++;
    if (t8_stb !== 0) begin
      n_err++;
      $display("FAIL ovf_arm_edge: stb %0d want 0", t8_stb);
    end
    run_tooth(100);
    n_cmp++;
    if (t8_stb !== 1 || t8_per !== 8'd100) begin
      n_err++;
      $display("FAIL ovf_resume: stb %0d per %0d, want 1 100", t8_stb, t8_per);
    end
  endtask

  // 255 cycles: edge lands on saturation and wins. 256 cycles: saturates first.
  task automatic test_sat_edge();
    int lens    [8] = '{100, 100, 255, 100, 256, 100, 100, 100};
    int exp_stb [8] = '{0, 0, 1, 1, 1, 0, 0, 1};
    int exp_per [8] = '{0, 0, 100, 255, 100, 0, 0, 100};
    int exp_ovf [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      run_tooth(lens[k]);
      n_cmp++;
      if (t8_stb !== exp_stb[k] || t8_ovf !== exp_ovf[k] ||
          (exp_stb[k] == 1 && t8_per !== 8'(exp_per[k]))) begin
        n_err++;
        $display("FAIL sat_edge[%0d]: stb %0d per %0d ovf %0d, want %0d %0d %0d",
                 k, t8_stb, t8_per, t8_ovf, exp_stb[k], exp_per[k], exp_ovf[k]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    for (int k = 0; k < 3; k++) run_tooth(256);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      vr_in = 1'b1;
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({vr_out, tooth_stb, gap_stb, period_ovf, tooth_period} !== 28'd0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got %h want 0", {vr_out, tooth_stb, gap_stb, period_ovf, tooth_period});
    end
    vr_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_tooth(256);
      n_cmp++;
      if (t_stb !== ((k == 2) ? 1 : 0) || (k == 2 && t_per !== 24'd256)) begin
        n_err++;
        $display("FAIL mid_reset_tooth[%0d]: stb %0d per %0d, want %0d 256", k, t_stb, t_per, (k == 2) ? 1 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_filter();
    test_square_wave();
    test_edge_fall();
    test_wheel();
    test_gap_boundary();
    test_overflow();
    test_sat_edge();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
